// File: rtl/serror_scoreboard_pkg.sv
// ============================================================================
// serror_scoreboard_pkg : shared FSM state type and default sizing constants
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package serror_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int C_DATAWIDTH = 8;
  localparam int C_CNTWIDTH  = 16;
  localparam int C_WINDOW    = 1000;

endpackage

`default_nettype wire

// File: rtl/serror_scoreboard_sat_counter.sv
// ============================================================================
// sat_counter : up-counter with enable and synchronous clear that sticks at all-ones
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/serror_scoreboard.sv
// ============================================================================
// serror_scoreboard : two-stage compare of DUT vs reference data over a fixed window
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module serror_scoreboard
  import serror_scoreboard_pkg::*;
#(
  parameter int DATAWIDTH = C_DATAWIDTH,
  parameter int CNTWIDTH  = C_CNTWIDTH,
  parameter int WINDOW    = C_WINDOW
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] meas,
  input  logic [DATAWIDTH-1:0] refd,
  input  logic                 valid,
  output logic [CNTWIDTH-1:0]  sample_cnt,
  output logic [CNTWIDTH-1:0]  err_cnt,
  output logic [CNTWIDTH-1:0]  first_idx,
  output logic [DATAWIDTH-1:0] first_meas,
  output logic [DATAWIDTH-1:0] first_ref,
  output logic                 done,
  output logic                 pass,
  output logic                 fail
);

  localparam logic [CNTWIDTH-1:0] C_WIN_LAST = CNTWIDTH'(WINDOW - 1);

  state_t               state_q, state_d;
  logic                 v1_q, v1_d;
  logic [DATAWIDTH-1:0] meas1_q, meas1_d;
  logic [DATAWIDTH-1:0] ref1_q, ref1_d;
  logic                 fail_q, fail_d;
  logic [CNTWIDTH-1:0]  first_idx_q, first_idx_d;
  logic [DATAWIDTH-1:0] first_meas_q, first_meas_d;
  logic [DATAWIDTH-1:0] first_ref_q, first_ref_d;

  logic w_accept;
  logic w_mismatch;
  logic w_last;

  // clr masks accounting so a sample in flight during restart is dropped
  assign w_accept   = v1_q && (state_q != ST_DONE) && !clr;
  assign w_mismatch = w_accept && (meas1_q != ref1_q);
  assign w_last     = w_accept && (sample_cnt == C_WIN_LAST);

  always_comb begin
    v1_d    = valid;
    meas1_d = meas;
    ref1_d  = refd;
    if (clr) begin
      v1_d    = 1'b0;
      meas1_d = '0;
      ref1_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (w_accept) state_d = w_last ? ST_DONE : ST_RUN;
        ST_RUN:  if (w_last)   state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // index is the pre-increment sample count, i.e. the 0-based sample number
  always_comb begin
    fail_d       = fail_q | w_mismatch;
    first_idx_d  = first_idx_q;
    first_meas_d = first_meas_q;
    first_ref_d  = first_ref_q;
    if (clr) begin
      fail_d       = 1'b0;
      first_idx_d  = '0;
      first_meas_d = '0;
      first_ref_d  = '0;
    end else if (w_mismatch && !fail_q) begin
      first_idx_d  = sample_cnt;
      first_meas_d = meas1_q;
      first_ref_d  = ref1_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      v1_q         <= 1'b0;
      meas1_q      <= '0;
      ref1_q       <= '0;
      fail_q       <= 1'b0;
      first_idx_q  <= '0;
      first_meas_q <= '0;
      first_ref_q  <= '0;
    end else begin
      state_q      <= state_d;
      v1_q         <= v1_d;
      meas1_q      <= meas1_d;
      ref1_q       <= ref1_d;
      fail_q       <= fail_d;
      first_idx_q  <= first_idx_d;
      first_meas_q <= first_meas_d;
      first_ref_q  <= first_ref_d;
    end
  end

  sat_counter #(.WIDTH(CNTWIDTH)) u_sample_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .i_clr (clr),
    .i_en  (w_accept),
    .o_cnt (sample_cnt)
  );

  sat_counter #(.WIDTH(CNTWIDTH)) u_err_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .i_clr (clr),
    .i_en  (w_mismatch),
    .o_cnt (err_cnt)
  );

  assign first_idx  = first_idx_q;
  assign first_meas = first_meas_q;
  assign first_ref  = first_ref_q;
  assign done       = (state_q == ST_DONE);
  assign fail       = fail_q;
  assign pass       = done & ~fail_q;

endmodule

`default_nettype wire

// File: doc/serror_scoreboard.md
SERROR_SCOREBOARD -- requirements
Module: serror_scoreboard

Interface
REQ-001 Parameter DATAWIDTH, default 8, is the width of the compared data words.
REQ-002 Parameter CNTWIDTH, default 16, is the width of all counters and indices.
REQ-003 Parameter WINDOW, default 1000, is the number of valid samples checked before the run is complete; legal range is 1 to 2^CNTWIDTH-1.
REQ-004 Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  is the reset: asynchronous, active-high.
REQ-006 clr  input  1  is a synchronous restart, active-high.
REQ-007 meas  input  DATAWIDTH  is the measured output of the device under test.
REQ-008 refd  input  DATAWIDTH  is the reference-model output.
REQ-009 valid  input  1  qualifies meas and refd for the current cycle.
REQ-010 sample_cnt  output  CNTWIDTH  is the number of valid samples accounted.
REQ-011 err_cnt  output  CNTWIDTH  is the number of mismatching samples, saturating.
REQ-012 first_idx  output  CNTWIDTH  is the 0-based sample index of the first mismatch.
REQ-013 first_meas / first_ref  output  DATAWIDTH each  hold the data of the first mismatch.
REQ-014 done  output  1  indicates WINDOW samples have been accounted.
REQ-015 pass  output  1  is done with err_cnt == 0.
REQ-016 fail  output  1  is a sticky flag, set when err_cnt > 0.

Function
REQ-017 The block shall be a two-stage pipeline: stage 1 registers valid, meas and refd; stage 2 compares them and updates the counters and flags.
REQ-018 A sample presented with valid=1 before rising edge N shall be reflected in all outputs after edge N+1.
REQ-019 The FSM shall have three states, IDLE, RUN and DONE; it leaves reset in IDLE.
REQ-020 IDLE shall go to RUN when the first registered valid sample is accounted; that sample shall count in the same cycle.
REQ-021 RUN shall go to DONE in the cycle sample_cnt reaches WINDOW; done shall assert in that same cycle.
REQ-022 In RUN, a cycle with registered valid=0 shall leave all counters unchanged, and the FSM shall stay in RUN.
REQ-023 In DONE, valid samples shall be ignored and all outputs shall hold until clr or Rst.
REQ-024 A mismatch is registered meas != registered refd on a valid sample; each mismatch shall increment err_cnt, saturating at all-ones.
REQ-025 first_idx, first_meas and first_ref shall be captured only on the first mismatch after reset or clr, and shall hold thereafter.
REQ-026 fail shall assert in the same cycle err_cnt becomes nonzero and shall stay asserted until clr or Rst.
REQ-027 pass shall equal done AND NOT fail.
REQ-028 clr shall have priority over sample accounting: in the cycle after clr, the outputs shall match reset values, the FSM shall be in IDLE and the stage-1 registers shall be cleared.
REQ-029 A valid sample coincident with clr shall be discarded.
REQ-030 If the WINDOW-th sample is also the first mismatch, done, fail and the first-error capture shall all update in the same cycle.

Reset
REQ-031 While Rst=1, every register shall be zero immediately, independent of Clk: sample_cnt, err_cnt, first_idx, first_meas, first_ref, done, pass, fail, the stage-1 registers and the FSM state (IDLE).
REQ-032 An Rst asserted mid-run shall abandon the run; after Rst deasserts, accounting shall restart from index 0.

Structure
REQ-033 A shared package shall hold the FSM state typedef (IDLE, RUN, DONE) and the default DATAWIDTH, CNTWIDTH and WINDOW constants.
REQ-034 A single sub-module, sat_counter (parameterised width, with enable, clear and saturation), shall implement err_cnt; sample_cnt shall reuse it.

Verification (DATAWIDTH=8, WINDOW=16)
REQ-035 Rst pulse, then 16 valid samples with meas==refd -> done=1 and pass=1 two cycles after the 16th sample is presented; err_cnt=0 and sample_cnt=16.
REQ-036 Samples 3 and 9 mismatch (sample 3 is meas=8'hA5, refd=8'h5A) -> first_idx=3, first_meas=8'hA5, first_ref=8'h5A, err_cnt=2; fail=1 from sample 3, pass=0 at done.
REQ-037 valid toggling 1,0,0,1 across 32 cycles, all samples matching -> sample_cnt counts only the valid cycles; done asserts exactly after the 16th valid sample.
REQ-038 Seven extra valid mismatching samples after done -> no output changes.
REQ-039 clr at sample 5, with a mismatch on that same cycle -> next cycle all outputs zero, the state is IDLE and the mismatch is not recorded.
REQ-040 Rst asserted asynchronously mid-cycle at sample 10 -> outputs go to zero before the next Clk edge; accounting then restarts at index 0.
REQ-041 Force err_cnt to saturate with CNTWIDTH=4, WINDOW=15 and all samples mismatching -> err_cnt=4'hF with no wrap; done=1 and fail=1.
